// File: rtl/fisr_regs_pkg.sv
// Shared constants for the fast-inverse-square-root register bank:
// bus widths, register byte offsets, register bit positions and response code.
package fisr_regs_pkg;

  localparam int C_S_AXI_DATA_WIDTH = 32;
  localparam int C_S_AXI_ADDR_WIDTH = 4;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_DIN    = 4'h8;
  localparam logic [3:0] ADDR_DOUT   = 4'hC;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_OVERRUN  = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Word index of a byte offset; the two low address bits never select anything.
  function automatic logic [1:0] reg_idx(input logic [3:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/fisr_axil_regs_if.sv
// AXI4-Lite bus bundle between a master and the fisr register bank.
interface fisr_axil_regs_if
  import fisr_regs_pkg::*;
#(
  parameter int AW = C_S_AXI_ADDR_WIDTH,
  parameter int DW = C_S_AXI_DATA_WIDTH
);

  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/fisr_axil_slv_if.sv
// AXI4-Lite channel handshakes: independent AW/W holding, one-shot register
// write strobe, and the registered B and R responses.
module fisr_axil_slv_if
  import fisr_regs_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARESET,
  fisr_axil_regs_if.slave s_axi,
  output logic        wr_en,
  output logic [1:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  output logic        rd_en,
  output logic [1:0]  rd_addr,
  input  logic [31:0] rd_data
);

  logic        aw_held_r, w_held_r, bvalid_r, rvalid_r;
  logic        awready_r, wready_r, arready_r;
  logic [1:0]  awidx_r;
  logic [31:0] wdata_r, rdata_r;
  logic [3:0]  wstrb_r;
  logic        aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic        aw_held_nx_s, w_held_nx_s, bvalid_nx_s, rvalid_nx_s;
  logic        unused_s;

  // Handshake detection and next-state of the holding/response flags.
  always_comb begin
    aw_hs_s  = s_axi.awvalid & awready_r;
    w_hs_s   = s_axi.wvalid & wready_r;
    ar_hs_s  = s_axi.arvalid & arready_r;
    commit_s = aw_held_r & w_held_r & ~bvalid_r;
    if (commit_s) aw_held_nx_s = 1'b0;
    else if (aw_hs_s) aw_held_nx_s = 1'b1;
    else aw_held_nx_s = aw_held_r;
    if (commit_s) w_held_nx_s = 1'b0;
    else if (w_hs_s) w_held_nx_s = 1'b1;
    else w_held_nx_s = w_held_r;
    if (commit_s) bvalid_nx_s = 1'b1;
    else if (s_axi.bready) bvalid_nx_s = 1'b0;
    else bvalid_nx_s = bvalid_r;
    if (ar_hs_s) rvalid_nx_s = 1'b1;
    else if (s_axi.rready) rvalid_nx_s = 1'b0;
    else rvalid_nx_s = rvalid_r;
  end

  // Channel state; ready flags are registered so they sit low through reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      rvalid_r  <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      arready_r <= 1'b0;
      awidx_r   <= 2'd0;
      wdata_r   <= 32'd0;
      wstrb_r   <= 4'd0;
      rdata_r   <= 32'd0;
    end else begin
      aw_held_r <= aw_held_nx_s;
      w_held_r  <= w_held_nx_s;
      bvalid_r  <= bvalid_nx_s;
      rvalid_r  <= rvalid_nx_s;
      awready_r <= ~aw_held_nx_s;
      wready_r  <= ~w_held_nx_s;
      arready_r <= ~rvalid_nx_s;
      if (aw_hs_s) awidx_r <= reg_idx(s_axi.awaddr);
      if (w_hs_s) begin
        wdata_r <= s_axi.wdata;
        wstrb_r <= s_axi.wstrb;
      end
      if (ar_hs_s) rdata_r <= rd_data;
    end
  end

  assign s_axi.awready = awready_r;
  assign s_axi.wready  = wready_r;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.arready = arready_r;
  assign s_axi.rdata   = rdata_r;
  assign s_axi.rresp   = RESP_OKAY;
  assign s_axi.rvalid  = rvalid_r;

  assign wr_en   = commit_s;
  assign wr_addr = awidx_r;
  assign wr_data = wdata_r;
  assign wr_strb = wstrb_r;
  assign rd_en   = ar_hs_s;
  assign rd_addr = reg_idx(s_axi.araddr);

  assign unused_s = ^{s_axi.awprot, s_axi.arprot};

endmodule

// File: rtl/fisr_axil_regs.sv
// Register bank in front of the fast-inverse-square-root core: operand,
// control/status, result capture, start handshake and interrupt.
module fisr_axil_regs
  import fisr_regs_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARESET,
  fisr_axil_regs_if.slave s_axi,
  output logic [31:0] core_din,
  output logic        core_start_valid,
  input  logic        core_start_ready,
  input  logic [31:0] core_dout,
  input  logic        core_done_valid,
  output logic        irq
);

  logic        wr_en_s, rd_en_s;
  logic [1:0]  wr_addr_s, rd_addr_s;
  logic [31:0] wr_data_s, rd_data_s;
  logic [3:0]  wr_strb_s;
  logic [31:0] din_r, dout_r, core_din_r, din_nx_s;
  logic        irq_en_r, busy_r, done_r, overrun_r, start_valid_r, irq_r;
  logic        wr_ctrl_s, wr_status_s, start_s, done_clr_s, ovr_clr_s;

  fisr_axil_slv_if u_slv (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .s_axi   (s_axi),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s),
    .wr_strb (wr_strb_s),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Decode of the committed write; control bits all live in byte lane 0.
  always_comb begin
    wr_ctrl_s   = wr_en_s & (wr_addr_s == reg_idx(ADDR_CTRL));
    wr_status_s = wr_en_s & (wr_addr_s == reg_idx(ADDR_STATUS));
    start_s     = wr_ctrl_s & wr_strb_s[0] & wr_data_s[CTRL_START];
    done_clr_s  = wr_status_s & wr_strb_s[0] & wr_data_s[ST_DONE];
    ovr_clr_s   = wr_status_s & wr_strb_s[0] & wr_data_s[ST_OVERRUN];
    din_nx_s    = din_r;
    for (int i = 0; i < 4; i++) begin
      if (wr_en_s && (wr_addr_s == reg_idx(ADDR_DIN)) && wr_strb_s[i])
        din_nx_s[8*i +: 8] = wr_data_s[8*i +: 8];
      else
        din_nx_s[8*i +: 8] = din_r[8*i +: 8];
    end
  end

  // Register state; a done strobe wins over a same-edge W1C, and START
  // judges BUSY by its pre-edge value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      din_r         <= 32'd0;
      dout_r        <= 32'd0;
      core_din_r    <= 32'd0;
      irq_en_r      <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      overrun_r     <= 1'b0;
      start_valid_r <= 1'b0;
      irq_r         <= 1'b0;
    end else begin
      din_r <= din_nx_s;
      if (wr_ctrl_s && wr_strb_s[0]) irq_en_r <= wr_data_s[CTRL_IRQ_EN];
      if (start_s && !busy_r) begin
        core_din_r    <= din_r;
        start_valid_r <= 1'b1;
      end else if (start_valid_r && core_start_ready) begin
        start_valid_r <= 1'b0;
      end
      if (start_s && !busy_r) busy_r <= 1'b1;
      else if (core_done_valid) busy_r <= 1'b0;
      done_r    <= core_done_valid | (done_r & ~done_clr_s);
      overrun_r <= (start_s & busy_r) | (overrun_r & ~ovr_clr_s);
      if (core_done_valid) dout_r <= core_dout;
      irq_r <= done_r & irq_en_r;
    end
  end

  // Read-data mux sampled by the slave on the AR handshake.
  always_comb begin
    rd_data_s = 32'd0;
    if (rd_en_s) begin
      case (rd_addr_s)
        2'd0:    rd_data_s = {30'd0, irq_en_r, 1'b0};
        2'd1:    rd_data_s = {29'd0, overrun_r, done_r, busy_r};
        2'd2:    rd_data_s = din_r;
        2'd3:    rd_data_s = dout_r;
        default: rd_data_s = 32'd0;
      endcase
    end else begin
      rd_data_s = 32'd0;
    end
  end

  assign core_din         = core_din_r;
  assign core_start_valid = start_valid_r;
  assign irq              = irq_r;

endmodule

// File: tb/tb_fisr_axil_regs.sv
// Directed self-checking bench for fisr_axil_regs.
module tb_fisr_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] core_din;
  logic        core_start_valid;
  logic        core_start_ready = 1'b0;
  logic [31:0] core_dout = 32'd0;
  logic        core_done_valid = 1'b0;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int run_len = 0;
  int last_run = 0;
  int starts = 0;
  logic prev_sv = 1'b0;
  logic early_b;
  logic [31:0] rd;
  logic stable;

  fisr_axil_regs_if axi ();

  fisr_axil_regs dut (
    .ACLK             (ACLK),
    .ARESET           (ARESET),
    .s_axi            (axi),
    .core_din         (core_din),
    .core_start_valid (core_start_valid),
    .core_start_ready (core_start_ready),
    .core_dout        (core_dout),
    .core_done_valid  (core_done_valid),
    .irq              (irq)
  );

  always #5 ACLK = ~ACLK;

  // Core model: holds start_ready low for the first 3 cycles of each request.
  always @(negedge ACLK) begin
    if (core_start_valid) begin
      if (!prev_sv) starts++;
      run_len++;
      if (run_len >= 4) core_start_ready = 1'b1;
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
      core_start_ready = 1'b0;
    end
    prev_sv = core_start_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead);
    int n;
    logic aw_hs, w_hs;
    early_b = 1'b0;
    axi.awaddr = addr;
    axi.wdata  = data;
    axi.wstrb  = strb;
    axi.wvalid = 1'b1;
    for (int i = 0; i < lead; i++) begin
      w_hs = axi.wvalid && axi.wready;
      @(posedge ACLK); #1;
      if (w_hs) axi.wvalid = 1'b0;
      if (axi.bvalid) early_b = 1'b1;
    end
    axi.awvalid = 1'b1;
    n = 0;
    while ((axi.awvalid || axi.wvalid) && n < 20) begin
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      @(posedge ACLK); #1;
      if (aw_hs) axi.awvalid = 1'b0;
      if (w_hs) axi.wvalid = 1'b0;
      n++;
    end
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    n = 0;
    while (!axi.bvalid && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk("bvalid", {31'd0, axi.bvalid}, 32'd1);
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    n = 0;
    while (!axi.arready && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    @(posedge ACLK); #1;
    axi.arvalid = 1'b0;
    n = 0;
    while (!axi.rvalid && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    data = axi.rvalid ? axi.rdata : 32'hDEAD_DEAD;
    @(posedge ACLK); #1;
  endtask

  task automatic pulse_done(input logic [31:0] v);
    core_dout = v;
    core_done_valid = 1'b1;
    @(posedge ACLK); #1;
    core_done_valid = 1'b0;
  endtask

  task automatic wait_start_idle();
    int n = 0;
    while (core_start_valid && n < 40) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk("start_idle", {31'd0, core_start_valid}, 32'd0);
    @(negedge ACLK);
    @(posedge ACLK); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.awaddr = 4'h0; axi.awprot = 3'd0; axi.awvalid = 1'b0;
    axi.wdata = 32'd0; axi.wstrb = 4'h0; axi.wvalid = 1'b0;
    axi.bready = 1'b1;
    axi.araddr = 4'h0; axi.arprot = 3'd0; axi.arvalid = 1'b0;
    axi.rready = 1'b1;

    // reset state
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", {31'd0, axi.awready}, 32'd0);
    chk("rst_arready", {31'd0, axi.arready}, 32'd0);
    chk("rst_wready", {31'd0, axi.wready}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("rel_ready", {29'd0, axi.awready, axi.wready, axi.arready}, 32'd7);

    // basic DIN write/readback, idle STATUS
    axi_write(4'h8, 32'h0004_0000, 4'hF, 0);
    axi_read(4'h8, rd);  chk("din_rb", rd, 32'h0004_0000);
    axi_read(4'h4, rd);  chk("status_idle", rd, 32'h0);

    // byte strobes, W leading AW by two cycles
    axi_write(4'h8, 32'h0, 4'hF, 0);
    axi_write(4'h8, 32'hFFFF_FFFF, 4'b0101, 0);
    axi_read(4'h8, rd);  chk("din_strb", rd, 32'h00FF_00FF);
    axi_write(4'h8, 32'h0, 4'hF, 0);
    axi_write(4'h8, 32'hFFFF_FFFF, 4'b0101, 2);
    chk("w_first_no_early_b", {31'd0, early_b}, 32'd0);
    axi_read(4'h8, rd);  chk("din_strb_wfirst", rd, 32'h00FF_00FF);

    // start with a stalled core
    axi_write(4'h8, 32'h1234_5678, 4'hF, 0);
    axi_write(4'h0, 32'h1, 4'hF, 0);
    chk("core_din", core_din, 32'h1234_5678);
    chk("starts1", starts, 32'd1);
    axi_read(4'h4, rd);  chk("status_busy", rd, 32'h1);
    wait_start_idle();
    chk("sv_len", last_run, 32'd4);
    pulse_done(32'h0000_8000);
    axi_read(4'hC, rd);  chk("dout", rd, 32'h0000_8000);
    axi_read(4'h4, rd);  chk("status_done", rd, 32'h2);
    axi_write(4'h0, 32'h1, 4'b1110, 0);
    chk("no_start_strb", starts, 32'd1);
    axi_read(4'h4, rd);  chk("status_nostart", rd, 32'h2);

    // overrun, DIN write while busy, W1C
    axi_write(4'h4, 32'h2, 4'hF, 0);
    axi_write(4'h8, 32'h0BAD_F00D, 4'hF, 0);
    axi_write(4'h0, 32'h1, 4'hF, 0);
    wait_start_idle();
    chk("starts2", starts, 32'd2);
    axi_write(4'h8, 32'hAAAA_5555, 4'hF, 0);
    chk("core_din_hold", core_din, 32'h0BAD_F00D);
    axi_read(4'h8, rd);  chk("din_busy", rd, 32'hAAAA_5555);
    axi_write(4'h0, 32'h1, 4'hF, 0);
    chk("starts_overrun", starts, 32'd2);
    axi_read(4'h4, rd);  chk("status_ovr", rd, 32'h5);
    axi_write(4'h4, 32'h6, 4'hF, 0);
    axi_read(4'h4, rd);  chk("status_w1c", rd, 32'h1);
    pulse_done(32'h9);
    axi_read(4'h4, rd);  chk("status_done2", rd, 32'h2);

    // interrupt
    axi_write(4'h4, 32'h2, 4'hF, 0);
    axi_write(4'h0, 32'h2, 4'hF, 0);
    axi_read(4'h0, rd);  chk("ctrl_rb", rd, 32'h2);
    chk("irq_idle", {31'd0, irq}, 32'd0);
    axi_write(4'h0, 32'h3, 4'hF, 0);
    wait_start_idle();
    pulse_done(32'h77);
    @(posedge ACLK); #1;
    chk("irq_set", {31'd0, irq}, 32'd1);
    fork
      axi_write(4'h4, 32'h2, 4'hF, 0);
      begin
        @(posedge ACLK); #1;
        pulse_done(32'h1234);
      end
    join
    axi_read(4'h4, rd);  chk("done_beats_w1c", rd, 32'h2);
    axi_read(4'hC, rd);  chk("dout2", rd, 32'h1234);
    chk("irq_kept", {31'd0, irq}, 32'd1);
    axi_write(4'h4, 32'h2, 4'hF, 0);
    chk("irq_clr", {31'd0, irq}, 32'd0);

    // back-pressure on B and R, then async reset
    axi_write(4'h8, 32'h1111_2222, 4'hF, 0);
    pulse_done(32'h55);
    @(posedge ACLK); #1;
    chk("irq_pre_rst", {31'd0, irq}, 32'd1);
    axi.bready = 1'b0;
    axi.rready = 1'b0;
    axi.awaddr = 4'h8; axi.wdata = 32'h3333_4444; axi.wstrb = 4'hF;
    axi.araddr = 4'h8;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
    @(posedge ACLK); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    chk("stall_rdata", axi.rdata, 32'h1111_2222);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge ACLK); #1;
      if (!(axi.bvalid && axi.rvalid && axi.rdata == 32'h1111_2222 && !axi.arready))
        stable = 1'b0;
    end
    chk("stall_stable", {31'd0, stable}, 32'd1);
    #3;
    ARESET = 1'b1;
    #1;
    chk("arst_valids", {30'd0, axi.bvalid, axi.rvalid}, 32'd0);
    chk("arst_readys", {29'd0, axi.awready, axi.wready, axi.arready}, 32'd0);
    chk("arst_rdata", axi.rdata, 32'd0);
    chk("arst_core_din", core_din, 32'd0);
    chk("arst_core", {30'd0, core_start_valid, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
